alu_div: RTL

- Iterative RV32M divider that sits directly downstream of the ALU operand mux.
- Consumes alu_src1 as the dividend and alu_src2 as the divisor, and computes DIV/DIVU/REM/REMU one quotient bit per cycle (radix-2 restoring).
- Holds the pipeline via div_busy_o; returns the result with a one-cycle div_done_o pulse to the execute-stage writeback select.

---
 rtl/alu_div_if.sv | 24 ++
 rtl/alu_div.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_div_if.sv
// Request/response bundle between the ALU operand mux and the iterative divider.
// The master side issues requests; the slave side (divider) returns busy/done/result.
interface alu_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  div_start_i;
  logic [1:0]            div_op_i;
  logic [DATA_WIDTH-1:0] div_src1_i;
  logic [DATA_WIDTH-1:0] div_src2_i;
  logic                  flush_i;
  logic                  div_busy_o;
  logic                  div_done_o;
  logic [DATA_WIDTH-1:0] div_result_o;

  modport master (
    output div_start_i, div_op_i, div_src1_i, div_src2_i, flush_i,
    input  div_busy_o, div_done_o, div_result_o
  );

  modport slave (
    input  div_start_i, div_op_i, div_src1_i, div_src2_i, flush_i,
    output div_busy_o, div_done_o, div_result_o
  );
endinterface

// File: rtl/alu_div.sv
// Radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Division by zero and signed overflow are resolved at the accepting edge.
module alu_div #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_div_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [DATA_WIDTH-1:0] ZERO_W  = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONES_W  = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  function automatic logic [DATA_WIDTH-1:0] neg_f(input logic [DATA_WIDTH-1:0] v);
    return (~v) + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] abs_f(input logic [DATA_WIDTH-1:0] v,
                                                  input logic                  is_signed);
    logic [DATA_WIDTH-1:0] r;
    if (is_signed && v[DATA_WIDTH-1]) begin
      r = neg_f(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
  logic                  qsign_q, qsign_d;
  logic                  rsign_q, rsign_d;
  logic                  rem_sel_q, rem_sel_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                  is_signed_s;
  logic                  accept_s;
  logic                  dvsr_zero_s;
  logic                  ovf_s;
  logic [DATA_WIDTH:0]   shifted_s;
  logic [DATA_WIDTH:0]   trial_s;
  logic                  qbit_s;
  logic [DATA_WIDTH-1:0] rem_nxt_s;
  logic [DATA_WIDTH-1:0] quot_nxt_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      quot_q    <= ZERO_W;
      rem_q     <= ZERO_W;
      dvsr_q    <= ZERO_W;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      result_q  <= ZERO_W;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      rem_sel_q <= rem_sel_d;
      result_q  <= result_d;
    end
  end

  // Next-state, operand capture and one restoring step per CALC cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    rem_sel_d = rem_sel_q;
    result_d  = result_q;

    is_signed_s = ~bus.div_op_i[0];
    accept_s    = bus.div_start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    dvsr_zero_s = (bus.div_src2_i == ZERO_W);
    ovf_s       = is_signed_s && (bus.div_src1_i == MIN_NEG) && (bus.div_src2_i == ONES_W);

    shifted_s  = {rem_q, quot_q[DATA_WIDTH-1]};
    trial_s    = shifted_s - {1'b0, dvsr_q};
    qbit_s     = ~trial_s[DATA_WIDTH];
    rem_nxt_s  = qbit_s ? trial_s[DATA_WIDTH-1:0] : shifted_s[DATA_WIDTH-1:0];
    quot_nxt_s = {quot_q[DATA_WIDTH-2:0], qbit_s};

    if (bus.flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            cnt_d     = CNT_ZERO;
            rem_d     = ZERO_W;
            quot_d    = abs_f(bus.div_src1_i, is_signed_s);
            dvsr_d    = abs_f(bus.div_src2_i, is_signed_s);
            qsign_d   = is_signed_s && (bus.div_src1_i[DATA_WIDTH-1] ^ bus.div_src2_i[DATA_WIDTH-1]);
            rsign_d   = is_signed_s && bus.div_src1_i[DATA_WIDTH-1];
            rem_sel_d = bus.div_op_i[1];
            // Corner cases bypass the iteration and deliver in the next cycle
            if (dvsr_zero_s) begin
              state_d  = S_DONE;
              result_d = bus.div_op_i[1] ? bus.div_src1_i : ONES_W;
            end else if (ovf_s) begin
              state_d  = S_DONE;
              result_d = bus.div_op_i[1] ? ZERO_W : MIN_NEG;
            end else begin
              state_d = S_CALC;
            end
          end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          rem_d  = rem_nxt_s;
          quot_d = quot_nxt_s;
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            if (rem_sel_q) begin
              result_d = rsign_q ? neg_f(rem_nxt_s) : rem_nxt_s;
            end else begin
              result_d = qsign_q ? neg_f(quot_nxt_s) : quot_nxt_s;
            end
          end else begin
            state_d = S_CALC;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.div_busy_o   = (state_q == S_CALC);
  assign bus.div_done_o   = (state_q == S_DONE);
  assign bus.div_result_o = result_q;

endmodule
